neural_layer_backward_seq: RTL and testbench
============================================

# neural_layer_backward_seq

Sequential backward pass for one fully-connected layer. It is the training-direction counterpart of the parallel forward layer and consumes the same flattened weight and bias layout. Given the upstream gradient and the layer's pre-activation values, it computes the activation-masked delta (the bias gradient) and the input gradient Wᵀ·delta. The input gradient feeds the previous layer's backward block. Arithmetic is time-multiplexed through one single-precision multiply-accumulate datapath.

## Interface
Parameters:
- IN_SIZE, 1, number of layer inputs (columns of W).
- OUT_SIZE, 1, number of layer outputs (rows of W).
- ACTIVATION, 0, derivative applied to the delta: 0 = ReLU; any other value = identity.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- start  input  1  request; sampled only in IDLE.
- weights  input  32*OUT_SIZE*IN_SIZE  row-major. W(o,i) is at word o*IN_SIZE+i; word k is at [32*k +: 32].
- z  input  32*OUT_SIZE  pre-activation values (matmul + bias) from the forward pass.
- grad_out  input  32*OUT_SIZE  dLoss/dOutput.
- grad_in  output  32*IN_SIZE  dLoss/dInput, registered.
- grad_bias  output  32*OUT_SIZE  delta, registered.
- busy  output  1  high while in MAC.
- done  output  1  one-cycle completion pulse.

All data words are IEEE-754 binary32.

## Operation
The FSM has three states: IDLE, MAC, DONE.

IDLE:
- On start, capture weights and grad_out into internal registers.
- Write grad_bias[o] = delta[o]:
  - ReLU: delta[o] = grad_out[o] if z[o] is strictly positive, otherwise +0 (0x00000000).
  - Strictly positive means sign bit 0 and bits[30:0] ≠ 0. Both +0 and −0 therefore give +0.
  - Identity: delta[o] = grad_out[o].
- Store delta internally.
- Clear the column index i, the row index o, and the accumulator acc (set to +0).
- Go to MAC.

MAC, one step per cycle:
- acc ← acc + W(i,o)·delta[o], where W(i,o) is read from word o*IN_SIZE+i.
- o increments. When o = OUT_SIZE−1, the step writes grad_in[i] with the completed sum, sets acc to +0, clears o, and increments i.
- After the step with i = IN_SIZE−1 and o = OUT_SIZE−1, go to DONE.

DONE:
- Assert done for exactly one cycle, then return to IDLE.

Inputs are ignored after capture. z is used only in the capture cycle.

Zero deltas are not skipped, so latency is fixed.

Rounding, NaN and Inf behaviour are inherited from the codebase's combinational single-precision multiplier and adder. This block adds no special-casing.

## Timing
- Reset values: grad_in = 0, grad_bias = 0, busy = 0, done = 0, state = IDLE, all internal registers 0.
- If start is sampled high at edge k:
  - busy is high from k to k+IN_SIZE*OUT_SIZE.
  - done is high for cycle k+IN_SIZE*OUT_SIZE+1.
  - Total latency from start to done is IN_SIZE*OUT_SIZE+1 cycles.
- grad_bias is valid from edge k.
- grad_in[i] updates at the end of column i. All of grad_in is valid from done until the next accepted start.
- start while busy or in DONE is ignored. start is accepted again in the first IDLE cycle after done.
- Reset asserted mid-operation:
  - Return to IDLE immediately with all outputs zeroed.
  - No done pulse.
  - Partial results are discarded.
- IN_SIZE = OUT_SIZE = 1 is legal: one MAC cycle, done two cycles after start.

## Structure
- Package nn_backward_pkg holds:
  - FLOAT_W = 32
  - FLOAT_ZERO = 32'h0000_0000
  - ACT_RELU = 0
  - the FSM state encoding
  - the is_strictly_positive(binary32) helper
- One sub-module, float_mac. It is combinational and computes acc_in + a·b using the codebase's single-precision multiplier and adder. The FSM registers the result.
- The o and i counters are sized $clog2 of their range, with a minimum of 1 bit.

## Test plan
Constants: 1.0 = 3F800000, 2.0 = 40000000, 3.0 = 40400000, 4.0 = 40800000, 0.5 = 3F000000, −1.0 = BF800000.

1. Basic ReLU case.
   - Stimulus: IN=OUT=2, W=[[1,2],[3,4]], z=[1,1], grad_out=[1,0.5], ReLU.
   - Response: grad_bias=[3F800000,3F000000]; grad_in=[40200000 (2.5), 40800000 (4.0)]; done on cycle 5 after start; busy high for 4 cycles.
2. ReLU masking.
   - Stimulus: same as 1 but z=[BF800000, 80000000].
   - Response: grad_bias=[0,0]; grad_in=[0,0]; latency unchanged.
3. Identity derivative.
   - Stimulus: ACTIVATION=1, z=[−1,−1], other values as in 1.
   - Response: same results as scenario 1.
4. Ignored start.
   - Stimulus: start pulsed on every cycle while busy and during DONE.
   - Response: exactly one done; results match scenario 1; the next start is accepted in IDLE only.
5. Reset mid-operation.
   - Stimulus: rst_n low during the 2nd MAC cycle.
   - Response: all outputs 0 immediately; no done. A restart then reproduces scenario 1 exactly.
6. Smallest size.
   - Stimulus: IN=OUT=1, W=[2], z=[3], grad_out=[0.5].
   - Response: grad_in=[3F800000]; grad_bias=[3F000000]; done 2 cycles after start.

Source files
------------

// File: rtl/nn_backward_pkg.sv
// rtl/nn_backward_pkg.sv - shared types, constants and helpers for the layer backward pass
package nn_backward_pkg;
  localparam int FLOAT_W = 32;
  localparam logic [FLOAT_W-1:0] FLOAT_ZERO = 32'h0000_0000;
  localparam int ACT_RELU = 0;

  typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_DONE} state_t;

  // Both signed zeros count as non-positive, so ReLU masks them.
  function automatic logic is_strictly_positive(input logic [FLOAT_W-1:0] x);
    return !x[31] && (x[30:0] != 31'd0);
  endfunction
endpackage

// File: rtl/neural_layer_backward_float_mac.sv
// rtl/neural_layer_backward_float_mac.sv - combinational binary32 acc_in + a*b
module float_mac
  import nn_backward_pkg::*;
(
  input  logic [FLOAT_W-1:0] acc_in,
  input  logic [FLOAT_W-1:0] a,
  input  logic [FLOAT_W-1:0] b,
  output logic [FLOAT_W-1:0] result
);
  // Round-to-nearest-even; subnormal inputs and results flush to signed zero.
  function automatic logic [31:0] fp_mul(input logic [31:0] x, input logic [31:0] y);
    logic        sign;
    logic [47:0] prod;
    logic [23:0] mant;
    logic        guard, sticky;
    logic [24:0] rnd;
    logic [9:0]  e;
    sign = x[31] ^ y[31];
    if (x[30:23] == 8'hFF || y[30:23] == 8'hFF) begin
      if ((x[30:23] == 8'hFF && x[22:0] != 23'd0) || (y[30:23] == 8'hFF && y[22:0] != 23'd0) ||
          x[30:23] == 8'd0 || y[30:23] == 8'd0)
        return 32'h7FC0_0000;
      return {sign, 8'hFF, 23'd0};
    end
    if (x[30:23] == 8'd0 || y[30:23] == 8'd0) return {sign, 31'd0};
    prod = {24'd0, 1'b1, x[22:0]} * {24'd0, 1'b1, y[22:0]};
    e = {2'b00, x[30:23]} + {2'b00, y[30:23]} - 10'd127;
    if (prod[47]) begin
      mant = prod[47:24]; guard = prod[23]; sticky = |prod[22:0];
      e = e + 10'd1;
    end else begin
      mant = prod[46:23]; guard = prod[22]; sticky = |prod[21:0];
    end
    rnd = {1'b0, mant} + {24'd0, guard & (sticky | mant[0])};
    if (rnd[24]) begin
      rnd = rnd >> 1;
      e = e + 10'd1;
    end
    if (e[9] || e == 10'd0) return {sign, 31'd0};
    if (e >= 10'd255) return {sign, 8'hFF, 23'd0};
    return {sign, e[7:0], rnd[22:0]};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] p, input logic [31:0] q);
    logic [31:0] x, y;
    logic [26:0] mx, my, sh;
    logic [27:0] sum;
    logic [7:0]  d;
    logic [9:0]  e;
    logic [24:0] rnd;
    int          lz;
    if (p[30:23] == 8'hFF || q[30:23] == 8'hFF) begin
      if ((p[30:23] == 8'hFF && p[22:0] != 23'd0) || (q[30:23] == 8'hFF && q[22:0] != 23'd0) ||
          (p[30:23] == 8'hFF && q[30:23] == 8'hFF && p[31] != q[31]))
        return 32'h7FC0_0000;
      return (p[30:23] == 8'hFF) ? p : q;
    end
    if (p[30:23] == 8'd0 && q[30:23] == 8'd0) return {p[31] & q[31], 31'd0};
    if (p[30:23] == 8'd0) return q;
    if (q[30:23] == 8'd0) return p;
    if (p[30:0] >= q[30:0]) begin x = p; y = q; end
    else begin x = q; y = p; end
    d  = x[30:23] - y[30:23];
    mx = {1'b1, x[22:0], 3'b000};
    my = {1'b1, y[22:0], 3'b000};
    if (d > 8'd26) sh = 27'd1;
    else begin
      sh = my >> d;
      sh[0] = sh[0] | (|(my & ~(27'h7FF_FFFF << d)));
    end
    e = {2'b00, x[30:23]};
    if (x[31] == y[31]) begin
      sum = {1'b0, mx} + {1'b0, sh};
      if (sum[27]) begin
        sum = {1'b0, sum[27:2], sum[1] | sum[0]};
        e = e + 10'd1;
      end
    end else begin
      sum = {1'b0, mx} - {1'b0, sh};
      if (sum == 28'd0) return 32'd0;
      lz = 27;
      for (int k = 0; k < 27; k++) if (sum[k]) lz = 26 - k;
      sum = sum << lz;
      e = e - 10'(lz);
    end
    if (e[9] || e == 10'd0) return {x[31], 31'd0};
    rnd = {1'b0, sum[26:3]} + {24'd0, sum[2] & (sum[1] | sum[0] | sum[3])};
    if (rnd[24]) begin
      rnd = rnd >> 1;
      e = e + 10'd1;
    end
    if (e >= 10'd255) return {x[31], 8'hFF, 23'd0};
    return {x[31], e[7:0], rnd[22:0]};
  endfunction

  assign result = fp_add(acc_in, fp_mul(a, b));
endmodule

// File: rtl/neural_layer_backward_seq.sv
// rtl/neural_layer_backward_seq.sv - sequential FC-layer backward pass: delta and W^T*delta
module neural_layer_backward_seq
  import nn_backward_pkg::*;
#(
  parameter int IN_SIZE    = 1,
  parameter int OUT_SIZE   = 1,
  parameter int ACTIVATION = 0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic [FLOAT_W*OUT_SIZE*IN_SIZE-1:0] weights,
  input  logic [FLOAT_W*OUT_SIZE-1:0]         z,
  input  logic [FLOAT_W*OUT_SIZE-1:0]         grad_out,
  output logic [FLOAT_W*IN_SIZE-1:0]          grad_in,
  output logic [FLOAT_W*OUT_SIZE-1:0]         grad_bias,
  output logic                                busy,
  output logic                                done
);
  localparam int OW = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam int IW = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;

  state_t                              state, state_next;
  logic [FLOAT_W*OUT_SIZE*IN_SIZE-1:0] w_q;
  logic [FLOAT_W*OUT_SIZE-1:0]         delta_next;
  logic [OW-1:0]                       o_idx;
  logic [IW-1:0]                       i_idx;
  logic [FLOAT_W-1:0]                  acc, w_word, d_word, mac_out;
  logic                                last_o, last_i;

  assign last_o = (o_idx == OW'(OUT_SIZE - 1));
  assign last_i = (i_idx == IW'(IN_SIZE - 1));
  assign busy   = (state == ST_MAC);
  assign done   = (state == ST_DONE);

  always_comb begin
    delta_next = '0;
    for (int o = 0; o < OUT_SIZE; o++) begin
      delta_next[FLOAT_W*o +: FLOAT_W] =
        (ACTIVATION != ACT_RELU || is_strictly_positive(z[FLOAT_W*o +: FLOAT_W]))
          ? grad_out[FLOAT_W*o +: FLOAT_W] : FLOAT_ZERO;
    end
  end

  // grad_bias doubles as the stored delta operand; the transpose read walks rows for a fixed column.
  always_comb begin
    w_word = w_q[FLOAT_W*(32'(o_idx)*IN_SIZE + 32'(i_idx)) +: FLOAT_W];
    d_word = grad_bias[FLOAT_W*32'(o_idx) +: FLOAT_W];
  end

  float_mac u_mac (
    .acc_in (acc),
    .a      (w_word),
    .b      (d_word),
    .result (mac_out)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_MAC;
      ST_MAC:  if (last_o && last_i) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q       <= '0;
      grad_bias <= '0;
      grad_in   <= '0;
      acc       <= FLOAT_ZERO;
      o_idx     <= '0;
      i_idx     <= '0;
    end else if (state == ST_IDLE && start) begin
      w_q       <= weights;
      grad_bias <= delta_next;
      acc       <= FLOAT_ZERO;
      o_idx     <= '0;
      i_idx     <= '0;
    end else if (state == ST_MAC) begin
      if (last_o) begin
        grad_in[FLOAT_W*32'(i_idx) +: FLOAT_W] <= mac_out;
        acc   <= FLOAT_ZERO;
        o_idx <= '0;
        if (!last_i) i_idx <= i_idx + IW'(1);
      end else begin
        acc   <= mac_out;
        o_idx <= o_idx + OW'(1);
      end
    end
  end
endmodule

// File: tb/tb_neural_layer_backward_seq.sv
// tb/tb_neural_layer_backward_seq.sv - scoreboard bench for neural_layer_backward_seq
module tb_neural_layer_backward_seq;
  typedef struct {
    logic [63:0] gi;
    logic [63:0] gb;
    int          k;
  } exp_t;

  localparam logic [127:0] W22 = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
  localparam logic [63:0]  G1  = {32'h3F000000, 32'h3F800000};
  localparam logic [63:0]  Z1  = {32'h3F800000, 32'h3F800000};
  localparam logic [63:0]  Z2  = {32'h80000000, 32'hBF800000};
  localparam logic [63:0]  ZN  = {32'hBF800000, 32'hBF800000};
  localparam logic [63:0]  GI1 = {32'h40800000, 32'h40200000};

  logic clk = 0, rst_n = 0;
  int   cyc = 0, n_checks = 0, n_fail = 0;
  int   busy_cnt_a = 0, busy_cnt_b = 0, busy_cnt_c = 0;
  exp_t q_a[$], q_b[$], q_c[$];

  logic         start_a = 0, start_b = 0, start_c = 0;
  logic [127:0] weights_a = W22, weights_b = W22;
  logic [31:0]  weights_c = 32'h40000000;
  logic [63:0]  z_a = '0, z_b = '0, grad_out_a = '0, grad_out_b = '0;
  logic [31:0]  z_c = 32'h40400000, grad_out_c = 32'h3F000000;
  logic [63:0]  grad_in_a, grad_in_b, grad_bias_a, grad_bias_b;
  logic [31:0]  grad_in_c, grad_bias_c;
  logic         busy_a, busy_b, busy_c, done_a, done_b, done_c;

  neural_layer_backward_seq #(.IN_SIZE(2), .OUT_SIZE(2), .ACTIVATION(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .weights(weights_a), .z(z_a), .grad_out(grad_out_a),
    .grad_in(grad_in_a), .grad_bias(grad_bias_a), .busy(busy_a), .done(done_a));
  neural_layer_backward_seq #(.IN_SIZE(2), .OUT_SIZE(2), .ACTIVATION(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .weights(weights_b), .z(z_b), .grad_out(grad_out_b),
    .grad_in(grad_in_b), .grad_bias(grad_bias_b), .busy(busy_b), .done(done_b));
  neural_layer_backward_seq #(.IN_SIZE(1), .OUT_SIZE(1), .ACTIVATION(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .weights(weights_c), .z(z_c), .grad_out(grad_out_c),
    .grad_in(grad_in_c), .grad_bias(grad_bias_c), .busy(busy_c), .done(done_c));

  always #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic score(input string name, input exp_t e, input logic [63:0] gi, input logic [63:0] gb,
                       input int n, input int busy_cnt);
    check({name, "_grad_in"}, gi, e.gi);
    check({name, "_grad_bias"}, gb, e.gb);
    check({name, "_latency"}, 64'(cyc - e.k + 1), 64'(n + 1));
    check({name, "_busy_cycles"}, 64'(busy_cnt), 64'(n));
  endtask

  // One monitor per instance: done pops the oldest expectation.
  initial forever begin
    @(negedge clk);
    if (!rst_n) busy_cnt_a = 0;
    else begin
      if (busy_a) busy_cnt_a++;
      if (done_a) begin
        if (q_a.size() == 0) check("a_spurious_done", 1, 0);
        else score("a", q_a.pop_front(), grad_in_a, grad_bias_a, 4, busy_cnt_a);
        busy_cnt_a = 0;
      end
    end
  end
  initial forever begin
    @(negedge clk);
    if (!rst_n) busy_cnt_b = 0;
    else begin
      if (busy_b) busy_cnt_b++;
      if (done_b) begin
        if (q_b.size() == 0) check("b_spurious_done", 1, 0);
        else score("b", q_b.pop_front(), grad_in_b, grad_bias_b, 4, busy_cnt_b);
        busy_cnt_b = 0;
      end
    end
  end
  initial forever begin
    @(negedge clk);
    if (!rst_n) busy_cnt_c = 0;
    else begin
      if (busy_c) busy_cnt_c++;
      if (done_c) begin
        if (q_c.size() == 0) check("c_spurious_done", 1, 0);
        else score("c", q_c.pop_front(), {32'd0, grad_in_c}, {32'd0, grad_bias_c}, 1, busy_cnt_c);
        busy_cnt_c = 0;
      end
    end
  end

  task automatic drain(input string tag);
    for (int t = 0; t < 40 && (q_a.size() + q_b.size() + q_c.size()) != 0; t++) @(negedge clk);
    check({tag, "_drain"}, 64'(q_a.size() + q_b.size() + q_c.size()), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic go_a(input string tag, input logic [63:0] zz, input logic [63:0] gi, input logic [63:0] gb);
    exp_t e;
    @(negedge clk);
    z_a = zz; grad_out_a = G1; start_a = 1;
    @(negedge clk);
    start_a = 0;
    e.gi = gi; e.gb = gb; e.k = cyc;
    q_a.push_back(e);
    check({tag, "_bias_at_start"}, grad_bias_a, gb);
    drain(tag);
  endtask

  initial begin
    exp_t e1, e2;
    repeat (2) @(negedge clk);
    check("rst_grad_in", grad_in_a, 0);
    check("rst_grad_bias", grad_bias_a, 0);
    check("rst_busy_done", {busy_a, done_a, busy_c, done_c}, 0);
    rst_n = 1;
    @(negedge clk);
    check("idle_outputs", {grad_in_b, grad_bias_b, busy_b, done_b}, 0);

    go_a("relu_basic", Z1, GI1, G1);
    go_a("relu_mask", Z2, 64'd0, 64'd0);

    // Identity derivative ignores the negative z.
    @(negedge clk);
    z_b = ZN; grad_out_b = G1; start_b = 1;
    @(negedge clk);
    start_b = 0;
    e1.gi = GI1; e1.gb = G1; e1.k = cyc;
    q_b.push_back(e1);
    drain("identity");

    // Start held through MAC and DONE is ignored; still high in the next IDLE it is accepted.
    @(negedge clk);
    z_a = Z1; grad_out_a = G1; start_a = 1;
    @(negedge clk);
    e1.gi = GI1; e1.gb = G1; e1.k = cyc;
    e2 = e1; e2.k = cyc + 6;
    q_a.push_back(e1);
    q_a.push_back(e2);
    repeat (6) @(negedge clk);
    start_a = 0;
    drain("ignored_start");

    // Reset during the second MAC cycle.
    @(negedge clk);
    z_a = Z1; grad_out_a = G1; start_a = 1;
    @(negedge clk);
    start_a = 0;
    @(negedge clk);
    check("pre_reset_busy", busy_a, 1);
    rst_n = 0;
    #1;
    check("reset_grad_bias", grad_bias_a, 0);
    check("reset_grad_in", grad_in_a, 0);
    check("reset_busy_done", {busy_a, done_a}, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (8) @(negedge clk);
    go_a("restart", Z1, GI1, G1);

    @(negedge clk);
    start_c = 1;
    @(negedge clk);
    start_c = 0;
    e1.gi = {32'd0, 32'h3F800000}; e1.gb = {32'd0, 32'h3F000000}; e1.k = cyc;
    q_c.push_back(e1);
    drain("smallest");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
